cmos_pixel_packer: RTL and testbench



---
 rtl/cmos_pixel_packer.sv | 184 ++++++++++++++++++
 tb/tb_cmos_pixel_packer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cmos_pixel_packer.sv
// Crops a window from the CMOS RGB565 stream, packs 4 pixels per 64-bit word and buffers
// the words in a small FIFO. Define CMOS_TESTPAT_EN to replace pixels with a coordinate pattern.
module cmos_pixel_packer #(
  parameter int unsigned H_START    = 0,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_START    = 0,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [15:0] pdata_i,
  input  logic        clr_err,
  output logic [63:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sof,
  output logic        m_eol,
  output logic [15:0] frame_cnt,
  output logic        ovf_err,
  output logic        short_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [12:0] HS = 13'(H_START);
  localparam logic [12:0] VS = 13'(V_START);
  localparam logic [12:0] HA = 13'(H_ACTIVE);
  localparam logic [12:0] VA = 13'(V_ACTIVE);

  logic             vs_d_q, de_d_q;
  logic             sync_seen_q, sync_seen_d;
  logic [11:0]      x_q, x_d, y_q, y_d;
  logic [63:0]      pack_q, pack_d;
  logic             filled_q, filled_d;
  logic             sof_pend_q, sof_pend_d;
  logic             req_q, req_d;
  logic [65:0]      req_word_q, req_word_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             ovf_q, ovf_d, short_q, short_d;
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [65:0]      mem_q [FIFO_DEPTH];

  logic        frame_start, line_end, in_win, eol_hit, short_set, ovf_set;
  logic        empty, full, pop, wr_en;
  logic [12:0] rel_x, rel_y;
  logic [1:0]  lane;
  logic [15:0] pix;
  logic [65:0] head;

  assign frame_start = vs_i && !vs_d_q;
  assign line_end    = de_d_q && !de_i;

  // Offsets wrap to >= 4096 when the counter is left of/above the window, so one compare covers both bounds.
  assign rel_x   = {1'b0, x_q} - HS;
  assign rel_y   = {1'b0, y_q} - VS;
  assign in_win  = sync_seen_q && de_i && (rel_x < HA) && (rel_y < VA);
  assign lane    = rel_x[1:0];
  assign eol_hit = (rel_x == HA - 13'd1);

`ifdef CMOS_TESTPAT_EN
  assign pix = {y_q[4:0], x_q[5:0], x_q[4:0]};
`else
  assign pix = pdata_i;
`endif

  // NOTE: every signal gets a default at the top of a combinational block so no path infers a latch.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    pack_d      = pack_q;
    filled_d    = filled_q;
    sof_pend_d  = sof_pend_q;
    sync_seen_d = sync_seen_q;
    frame_cnt_d = frame_cnt_q;
    req_d       = 1'b0;
    req_word_d  = req_word_q;
    short_set   = 1'b0;

    if (in_win) begin
      if (lane == 2'd3) begin
        req_d      = 1'b1;
        req_word_d = {sof_pend_q, eol_hit, pix, pack_q[47:0]};
        pack_d     = '0;
        filled_d   = 1'b0;
        sof_pend_d = 1'b0;
      end else begin
        pack_d[{lane, 4'b0000} +: 16] = pix;
        filled_d = 1'b1;
      end
    end else if (line_end && filled_q) begin
      // Cleared lanes already hold zero, so the partial word is padded for free.
      req_d      = 1'b1;
      req_word_d = {sof_pend_q, 1'b1, pack_q};
      pack_d     = '0;
      filled_d   = 1'b0;
      sof_pend_d = 1'b0;
      short_set  = 1'b1;
    end

    if (de_i) begin
      x_d = x_q + 12'd1;
    end else if (line_end) begin
      x_d = '0;
      y_d = (y_q == 12'hFFF) ? y_q : y_q + 12'd1;
    end

    // A word completed in this cycle is already captured in req_word_d before the restart.
    if (frame_start) begin
      x_d         = '0;
      y_d         = '0;
      pack_d      = '0;
      filled_d    = 1'b0;
      sof_pend_d  = 1'b1;
      sync_seen_d = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop     = !empty && m_ready;
  assign wr_en   = req_q && (!full || pop);
  assign ovf_set = req_q && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    ovf_d    = ovf_set   || (ovf_q   && !clr_err);
    short_d  = short_set || (short_q && !clr_err);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_q      <= 1'b1;  // a VSYNC already high at reset release must not count as a frame start
      de_d_q      <= 1'b0;
      sync_seen_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      pack_q      <= '0;
      filled_q    <= 1'b0;
      sof_pend_q  <= 1'b0;
      req_q       <= 1'b0;
      req_word_q  <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      short_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      vs_d_q      <= vs_i;
      de_d_q      <= de_i;
      sync_seen_q <= sync_seen_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pack_q      <= pack_d;
      filled_q    <= filled_d;
      sof_pend_q  <= sof_pend_d;
      req_q       <= req_d;
      req_word_q  <= req_word_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      short_q     <= short_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers define validity and the outputs are gated when empty.
  always_ff @(posedge pclk) begin
    if (wr_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= req_word_q;
  end

  assign head                   = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign {m_sof, m_eol, m_data} = empty ? 66'd0 : head;
  assign m_valid                = !empty;
  assign frame_cnt              = frame_cnt_q;
  assign ovf_err                = ovf_q;
  assign short_err              = short_q;

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Directed bench for cmos_pixel_packer: two instances with different crop windows share one stream.
module tb_cmos_pixel_packer;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs_i = 1'b0, de_i = 1'b0, clr_err = 1'b0;
  logic [15:0] pdata_i = '0;
  logic        m_ready_a = 1'b1, m_ready_b = 1'b1;

  logic [63:0] m_data_a, m_data_b;
  logic        m_valid_a, m_valid_b, m_sof_a, m_sof_b, m_eol_a, m_eol_b;
  logic [15:0] frame_cnt_a, frame_cnt_b;
  logic        ovf_a, ovf_b, short_a, short_b;

  int checks = 0;
  int failures = 0;
  logic [65:0] cap_a[$];
  logic [65:0] cap_b[$];

  always #5 pclk = ~pclk;

  cmos_pixel_packer #(.H_START(0), .H_ACTIVE(8), .V_START(0), .V_ACTIVE(2), .FIFO_DEPTH(4)) dut_a (
    .pclk(pclk), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i), .clr_err(clr_err),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a), .m_sof(m_sof_a), .m_eol(m_eol_a),
    .frame_cnt(frame_cnt_a), .ovf_err(ovf_a), .short_err(short_a));

  cmos_pixel_packer #(.H_START(4), .H_ACTIVE(4), .V_START(1), .V_ACTIVE(1), .FIFO_DEPTH(4)) dut_b (
    .pclk(pclk), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i), .clr_err(clr_err),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .m_sof(m_sof_b), .m_eol(m_eol_b),
    .frame_cnt(frame_cnt_b), .ovf_err(ovf_b), .short_err(short_b));

  // Record each accepted word half a cycle before the edge that pops it.
  always @(negedge pclk) begin
    if (m_valid_a && m_ready_a) cap_a.push_back({m_sof_a, m_eol_a, m_data_a});
    if (m_valid_b && m_ready_b) cap_b.push_back({m_sof_b, m_eol_b, m_data_b});
  end

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] w(input logic sof, input logic eol, input logic [63:0] d);
    return {sof, eol, d};
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vs_pulse();
    vs_i = 1'b1; tick();
    vs_i = 1'b0; tick();
  endtask

  task automatic send_line(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      de_i = 1'b1; pdata_i = base + 16'(i); tick();
    end
    de_i = 1'b0; pdata_i = '0; tick();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; tick();
    clr_err = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    idle(3);
    check("rst_valid", m_valid_a, 1'b0);
    check("rst_data", m_data_a, 64'd0);
    check("rst_sof_eol", {m_sof_a, m_eol_a}, 2'b00);
    check("rst_frame_cnt", frame_cnt_a, 16'd0);
    check("rst_errs", {ovf_a, short_a}, 2'b00);
    rst_n = 1'b1;
    idle(3);

    // Basic 2x8 frame with latency checks on the first word
    cap_a.delete();
    vs_pulse();
    for (int i = 0; i < 8; i++) begin
      de_i = 1'b1; pdata_i = 16'(i + 1); tick();
      if (i == 3) check("t1_lat_not_yet", m_valid_a, 1'b0);
      if (i == 4) begin
        check("t1_lat_valid", m_valid_a, 1'b1);
        check("t1_head", {m_sof_a, m_eol_a, m_data_a}, w(1'b1, 1'b0, 64'h0004_0003_0002_0001));
      end
    end
    de_i = 1'b0; pdata_i = '0; tick();
    send_line(8, 16'h0009);
    idle(8);
    check("t1_count", cap_a.size(), 4);
    check("t1_w0", cap_a[0], w(1'b1, 1'b0, 64'h0004_0003_0002_0001));
    check("t1_w1", cap_a[1], w(1'b0, 1'b1, 64'h0008_0007_0006_0005));
    check("t1_w2", cap_a[2], w(1'b0, 1'b0, 64'h000C_000B_000A_0009));
    check("t1_w3", cap_a[3], w(1'b0, 1'b1, 64'h0010_000F_000E_000D));
    check("t1_frame_cnt", frame_cnt_a, 16'd1);

    // Offset window on dut_b: 3 lines of 12 pixels
    cap_b.delete();
    vs_pulse();
    for (int l = 0; l < 3; l++) send_line(12, 16'((l + 1) * 256));
    idle(8);
    check("t2_count", cap_b.size(), 1);
    check("t2_w0", cap_b[0], w(1'b1, 1'b1, 64'h0207_0206_0205_0204));
    check("t2_frame_cnt", frame_cnt_b, 16'd2);

    // Overflow with consumer stalled
    m_ready_a = 1'b0;
    cap_a.delete();
    vs_pulse();
    send_line(8, 16'h0021);
    send_line(8, 16'h0031);
    vs_pulse();
    send_line(4, 16'h0041);
    idle(3);
    check("t3_valid_held", m_valid_a, 1'b1);
    check("t3_ovf_set", ovf_a, 1'b1);
    check("t3_short_clear", short_a, 1'b0);
    check("t3_head", {m_sof_a, m_eol_a, m_data_a}, w(1'b1, 1'b0, 64'h0024_0023_0022_0021));
    m_ready_a = 1'b1;
    idle(8);
    check("t3_count", cap_a.size(), 4);
    check("t3_w0", cap_a[0], w(1'b1, 1'b0, 64'h0024_0023_0022_0021));
    check("t3_w1", cap_a[1], w(1'b0, 1'b1, 64'h0028_0027_0026_0025));
    check("t3_w2", cap_a[2], w(1'b0, 1'b0, 64'h0034_0033_0032_0031));
    check("t3_w3", cap_a[3], w(1'b0, 1'b1, 64'h0038_0037_0036_0035));
    check("t3_ovf_sticky", ovf_a, 1'b1);
    pulse_clr();
    check("t3_ovf_cleared", ovf_a, 1'b0);

    // Short line: 6 pixels into an 8-pixel window
    cap_a.delete();
    vs_pulse();
    send_line(6, 16'h0051);
    idle(6);
    check("t4_count", cap_a.size(), 2);
    check("t4_w0", cap_a[0], w(1'b1, 1'b0, 64'h0054_0053_0052_0051));
    check("t4_w1", cap_a[1], w(1'b0, 1'b1, 64'h0000_0000_0056_0055));
    check("t4_short_set", short_a, 1'b1);
    pulse_clr();
    check("t4_short_cleared", short_a, 1'b0);

    // VSYNC rising in the middle of a pixel group
    cap_a.delete();
    vs_pulse();
    de_i = 1'b1; pdata_i = 16'h0061; tick();
    pdata_i = 16'h0062; tick();
    vs_i = 1'b1; pdata_i = 16'h0063; tick();
    for (int i = 0; i < 4; i++) begin
      pdata_i = 16'h0071 + 16'(i); tick();
    end
    vs_i = 1'b0; de_i = 1'b0; pdata_i = '0; tick();
    idle(6);
    check("t5_count", cap_a.size(), 1);
    check("t5_w0", cap_a[0], w(1'b1, 1'b0, 64'h0074_0073_0072_0071));
    check("t5_frame_cnt", frame_cnt_a, 16'd7);

    // Asynchronous reset mid-line
    m_ready_a = 1'b0;
    vs_pulse();
    send_line(6, 16'h00A1);
    idle(4);
    check("t6_pre_short", short_a, 1'b1);
    check("t6_pre_valid", m_valid_a, 1'b1);
    de_i = 1'b1; pdata_i = 16'h0081; tick();
    pdata_i = 16'h0082; tick();
    rst_n = 1'b0; de_i = 1'b0; pdata_i = '0;
    idle(3);
    check("t6_rst_valid", m_valid_a, 1'b0);
    check("t6_rst_data", m_data_a, 64'd0);
    check("t6_rst_sof_eol", {m_sof_a, m_eol_a}, 2'b00);
    check("t6_rst_frame_cnt", frame_cnt_a, 16'd0);
    check("t6_rst_errs", {ovf_a, short_a}, 2'b00);
    rst_n = 1'b1;
    m_ready_a = 1'b1;
    cap_a.delete();
    idle(2);
    send_line(8, 16'h0081);
    idle(6);
    check("t6_no_sync_count", cap_a.size(), 0);
    check("t6_no_sync_valid", m_valid_a, 1'b0);
    vs_pulse();
    send_line(8, 16'h0091);
    idle(6);
    check("t6_count", cap_a.size(), 2);
    check("t6_w0", cap_a[0], w(1'b1, 1'b0, 64'h0094_0093_0092_0091));
    check("t6_w1", cap_a[1], w(1'b0, 1'b1, 64'h0098_0097_0096_0095));
    check("t6_frame_cnt", frame_cnt_a, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
